// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and register map for the interrupt controller.
package irq_pkg;

  localparam int unsigned NUM_SRC     = 8;
  localparam int unsigned LEVEL_W     = 2;
  localparam int unsigned STACK_DEPTH = 3;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PRIO = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  function automatic logic [LEVEL_W-1:0] prio_of(input logic [NUM_SRC*LEVEL_W-1:0] prio,
                                                 input int unsigned idx);
    return prio[idx*LEVEL_W +: LEVEL_W];
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-source rising-edge detector; IRQ_SYNC_EN adds a 2-flop synchronizer in front.
module irq_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);

`ifdef IRQ_SYNC_EN
  localparam int unsigned RDY_W = 3;
  logic [1:0] sync_q, sync_d;
  logic       smp;

  always_comb begin
    sync_d = {sync_q[0], src};
    smp    = sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end
`else
  localparam int unsigned RDY_W = 1;
  logic smp;

  always_comb smp = src;
`endif

  logic [RDY_W-1:0] rdy_q, rdy_d;
  logic             prev_q, prev_d;

  // Edges are suppressed until the history holds a real post-reset sample.
  always_comb begin
    prev_d    = smp;
    rdy_d     = rdy_q << 1;
    rdy_d[0]  = 1'b1;
    rise      = rdy_q[RDY_W-1] & smp & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rdy_q  <= '0;
    end else begin
      prev_q <= prev_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised, nesting interrupt controller with in-service level stack.
// Optional input synchronisation via IRQ_SYNC_EN (see irq_edge_det).
module irq_ctrl
  import irq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  irq_src,
  output logic [2:0]          interruptSignal,
  output logic [2:0]          irq_id,
  input  logic                irq_ack,
  input  logic                eoi,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata
);

  logic [NUM_SRC-1:0]                    rise;
  logic [NUM_SRC-1:0]                    mask_q, mask_d, pend_q, pend_d;
  logic [NUM_SRC*LEVEL_W-1:0]            prio_q, prio_d;
  logic [STACK_DEPTH-1:0][LEVEL_W-1:0]   stk_q, stk_d;
  logic [1:0]                            depth_q, depth_d;
  logic                                  spur_q, spur_d;
  irq_state_e                            state_q, state_d;
  logic [2:0]                            int_q, int_d, id_q, id_d;
  logic [LEVEL_W-1:0]                    cur_level, best_lvl, lvl;
  logic [2:0]                            best_id;
  logic                                  any_elig, ack_ok;
  logic                                  unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_det u_det (
      .clk  (clk),
      .rst_n(rst_n),
      .src  (irq_src[g]),
      .rise (rise[g])
    );
  end

  always_comb begin
    cur_level = (depth_q == 2'd0) ? '0 : stk_q[depth_q - 2'd1];
  end

  // Strict compare keeps the lowest index on equal priority.
  always_comb begin
    best_lvl = '0;
    best_id  = '0;
    lvl      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      lvl = prio_of(prio_q, i);
      if (pend_q[i] && mask_q[i] && (lvl > cur_level) && (lvl > best_lvl)) begin
        best_lvl = lvl;
        best_id  = 3'(i);
      end
    end
    any_elig = (best_lvl != '0);
  end

  always_comb begin
    mask_d  = mask_q;
    prio_d  = prio_q;
    pend_d  = pend_q;
    spur_d  = spur_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    state_d = state_q;
    int_d   = '0;
    id_d    = '0;
    ack_ok  = irq_ack && (state_q == ST_REQ);

    if (cfg_we) begin
      case (cfg_addr)
        ADDR_MASK: mask_d = cfg_wdata[NUM_SRC-1:0];
        ADDR_PRIO: prio_d = cfg_wdata[NUM_SRC*LEVEL_W-1:0];
        ADDR_PEND: pend_d = pend_d & ~cfg_wdata[NUM_SRC-1:0];
        ADDR_STAT: if (cfg_wdata[8]) spur_d = 1'b0;
        default: ;
      endcase
    end

    if (ack_ok) pend_d[id_q] = 1'b0;
    pend_d = pend_d | rise;

    // Pop first, then push: a simultaneous ack/eoi replaces the top entry.
    if (eoi) begin
      if (depth_q == 2'd0) spur_d  = 1'b1;
      else                 depth_d = depth_q - 2'd1;
    end
    if (ack_ok && (depth_d < 2'(STACK_DEPTH))) begin
      stk_d[depth_d] = int_q[LEVEL_W-1:0];
      depth_d        = depth_d + 2'd1;
    end

    case (state_q)
      ST_IDLE: if (any_elig) state_d = ST_REQ;
      ST_REQ:  if (irq_ack || !any_elig) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_REQ) begin
      int_d = 3'(best_lvl);
      id_d  = best_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      prio_q  <= '0;
      pend_q  <= '0;
      spur_q  <= 1'b0;
      stk_q   <= '0;
      depth_q <= '0;
      state_q <= ST_IDLE;
      int_q   <= '0;
      id_q    <= '0;
    end else begin
      mask_q  <= mask_d;
      prio_q  <= prio_d;
      pend_q  <= pend_d;
      spur_q  <= spur_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      state_q <= state_d;
      int_q   <= int_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[NUM_SRC-1:0] = mask_q;
      ADDR_PRIO: cfg_rdata[NUM_SRC*LEVEL_W-1:0] = prio_q;
      ADDR_PEND: cfg_rdata[NUM_SRC-1:0] = pend_q;
      ADDR_STAT: begin
        cfg_rdata[1:0] = depth_q;
        cfg_rdata[3:2] = cur_level;
        cfg_rdata[8]   = spur_q;
      end
      default: ;
    endcase
  end

  always_comb unused_wdata = ^cfg_wdata[31:16];

  assign interruptSignal = int_q;
  assign irq_id          = id_q;

endmodule
